// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_hazard_unit
//  Description : Operand-forwarding select and load-use stall detection for an
//                in-order pipeline. Tracks the instruction in EX plus DEPTH
//                older stage records (stage 1 = EX/MEM ... stage DEPTH = MEM/WB)
//                and picks, per EX source operand, the nearest older producer.
//                A load in EX whose result is needed by the instruction in ID
//                raises stall for one cycle so that the consumer meets the load
//                in stage 2, where the loaded data is forwardable.
//  Ports       : clk, rst            clock, synchronous active-high reset
//                id_valid            instruction present in ID
//                id_src/id_src_used  ID source indices (REG_W each) / used mask
//                id_rd/id_reg_write/id_mem_read  ID destination and flags
//                flush               squash the instruction moving ID->EX
//                fwd_sel             per-source select, 0 = regfile, k = stage k
//                stall               hold PC and IF/ID, bubble into EX
//                stall_cnt/fwd_cnt   saturating performance counters
//  Revision    : 1.0  initial release
// ============================================================================
module fwd_hazard_unit #(
    parameter  int REG_W = 5,
    parameter  int NSRC  = 2,
    parameter  int DEPTH = 2,
    parameter  int CNT_W = 16,
    localparam int SEL_W = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [NSRC*REG_W-1:0]   id_src,
    input  logic [NSRC-1:0]         id_src_used,
    input  logic [REG_W-1:0]        id_rd,
    input  logic                    id_reg_write,
    input  logic                    id_mem_read,
    input  logic                    flush,
    output logic [NSRC*SEL_W-1:0]   fwd_sel,
    output logic                    stall,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        fwd_cnt
);

    // EX record
    logic                   r_exValid;
    logic [NSRC*REG_W-1:0]  r_exSrc;
    logic [NSRC-1:0]        r_exSrcUsed;
    logic [REG_W-1:0]       r_exRd;
    logic                   r_exRegWrite;
    logic                   r_exMemRead;

    // Older stage records, index 1 is nearest to EX
    logic [DEPTH:1]         r_stValid;
    logic [DEPTH:1]         r_stRegWrite;
    logic [REG_W-1:0]       r_stRd [1:DEPTH];

    logic [CNT_W-1:0]       r_stallCnt;
    logic [CNT_W-1:0]       r_fwdCnt;

    logic [NSRC*SEL_W-1:0]  w_fwdSel;
    logic                   w_exLoadHit;
    logic                   w_stage1LoadHit;
    logic                   w_stall;
    logic                   w_exLoad;

    // Load in EX feeding a used ID source: data is not available until the
    // load reaches stage 2, so the consumer must wait one cycle.
    always_comb begin
        w_exLoadHit = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (id_src_used[i] && (id_src[i*REG_W +: REG_W] == r_exRd))
                w_exLoadHit = 1'b1;
        end
        w_exLoadHit = w_exLoadHit && r_exValid && r_exMemRead &&
                      r_exRegWrite && (r_exRd != '0);
    end

    // With a single forwarding stage the load can never be forwarded, so the
    // consumer keeps stalling while the load occupies stage 1 as well.
    if (DEPTH == 1) begin : g_stage1Load
        logic r_st1MemRead;
        logic w_hit;

        always_ff @(posedge clk) begin
            if (rst)
                r_st1MemRead <= 1'b0;
            else
                r_st1MemRead <= r_exValid && r_exMemRead;
        end

        always_comb begin
            w_hit = 1'b0;
            for (int i = 0; i < NSRC; i++) begin
                if (id_src_used[i] && (id_src[i*REG_W +: REG_W] == r_stRd[1]))
                    w_hit = 1'b1;
            end
        end

        assign w_stage1LoadHit = w_hit && r_stValid[1] && r_st1MemRead &&
                                 r_stRegWrite[1] && (r_stRd[1] != '0);
    end else begin : g_noStage1Load
        assign w_stage1LoadHit = 1'b0;
    end

    assign w_stall = !rst && id_valid && (w_exLoadHit || w_stage1LoadHit);

    // Walk from the farthest stage to the nearest so that the nearest match
    // overwrites any farther one; non-matching nearer stages leave it alone.
    always_comb begin
        w_fwdSel = '0;
        for (int i = 0; i < NSRC; i++) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (r_exValid && r_exSrcUsed[i] && r_stValid[k] && r_stRegWrite[k] &&
                    (r_stRd[k] == r_exSrc[i*REG_W +: REG_W]) && (r_stRd[k] != '0))
                    w_fwdSel[i*SEL_W +: SEL_W] = SEL_W'(k);
            end
        end
        if (rst)
            w_fwdSel = '0;
    end

    assign w_exLoad = id_valid && !w_stall && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exValid    <= 1'b0;
            r_exSrc      <= '0;
            r_exSrcUsed  <= '0;
            r_exRd       <= '0;
            r_exRegWrite <= 1'b0;
            r_exMemRead  <= 1'b0;
            r_stValid    <= '0;
            r_stRegWrite <= '0;
            for (int k = 1; k <= DEPTH; k++)
                r_stRd[k] <= '0;
            r_stallCnt   <= '0;
            r_fwdCnt     <= '0;
        end else begin
            r_exValid    <= w_exLoad;
            r_exSrc      <= w_exLoad ? id_src       : '0;
            r_exSrcUsed  <= w_exLoad ? id_src_used  : '0;
            r_exRd       <= w_exLoad ? id_rd        : '0;
            r_exRegWrite <= w_exLoad && id_reg_write;
            r_exMemRead  <= w_exLoad && id_mem_read;

            r_stValid[1]    <= r_exValid;
            r_stRegWrite[1] <= r_exRegWrite;
            r_stRd[1]       <= r_exRd;
            for (int k = 2; k <= DEPTH; k++) begin
                r_stValid[k]    <= r_stValid[k-1];
                r_stRegWrite[k] <= r_stRegWrite[k-1];
                r_stRd[k]       <= r_stRd[k-1];
            end

            if (w_stall && (r_stallCnt != '1))
                r_stallCnt <= r_stallCnt + 1'b1;
            if ((|w_fwdSel) && (r_fwdCnt != '1))
                r_fwdCnt <= r_fwdCnt + 1'b1;
        end
    end

    assign fwd_sel   = w_fwdSel;
    assign stall     = w_stall;
    assign stall_cnt = r_stallCnt;
    assign fwd_cnt   = r_fwdCnt;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fwd_hazard_unit
//  Description : Scoreboard bench for fwd_hazard_unit. A driver issues
//                directed and random ID traffic, predicts the outputs from an
//                instruction-history model and queues them; a monitor on the
//                falling edge pops and compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fwd_hazard_unit;

    localparam int REG_W = 5;
    localparam int NSRC  = 2;
    localparam int DEPTH = 2;
    localparam int CNT_W = 16;
    localparam int SEL_W = $clog2(DEPTH + 1);

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   id_valid = 1'b0;
    logic [NSRC*REG_W-1:0]  id_src = '0;
    logic [NSRC-1:0]        id_src_used = '0;
    logic [REG_W-1:0]       id_rd = '0;
    logic                   id_reg_write = 1'b0;
    logic                   id_mem_read = 1'b0;
    logic                   flush = 1'b0;
    logic [NSRC*SEL_W-1:0]  fwd_sel;
    logic                   stall;
    logic [CNT_W-1:0]       stall_cnt;
    logic [CNT_W-1:0]       fwd_cnt;

    always #5 clk = ~clk;

    fwd_hazard_unit #(
        .REG_W(REG_W), .NSRC(NSRC), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush), .fwd_sel(fwd_sel),
        .stall(stall), .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
    );

    typedef struct packed {
        logic                         v;
        logic                         rw;
        logic                         mr;
        logic [REG_W-1:0]             rd;
        logic [NSRC-1:0]              used;
        logic [NSRC-1:0][REG_W-1:0]   src;
    } rec_t;

    typedef struct packed {
        logic                   stall;
        logic [NSRC*SEL_W-1:0]  sel;
        logic [CNT_W-1:0]       sc;
        logic [CNT_W-1:0]       fc;
        logic                   cntValid;
    } exp_t;

    // Instruction history: entry 0 is the instruction in EX, entry k the one k
    // cycles older (stage k).
    rec_t pipe[$];
    int   mStall = 0;
    int   mFwd   = 0;
    bit   known  = 0;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic rec_t mk(bit v, logic [NSRC-1:0] used, int s0, int s1,
                                int rd, bit rw, bit mr);
        rec_t x;
        x.v      = v;
        x.used   = used;
        x.src[0] = REG_W'(s0);
        x.src[1] = REG_W'(s1);
        x.rd     = REG_W'(rd);
        x.rw     = rw;
        x.mr     = mr;
        return x;
    endfunction

    function automatic rec_t randRec();
        return mk($urandom_range(0, 9) != 0, NSRC'($urandom_range(0, 3)),
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0);
    endfunction

    // Nearest older producer of each EX source, searched outward from stage 1.
    function automatic logic [NSRC*SEL_W-1:0] refSel();
        logic [NSRC*SEL_W-1:0] s = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (pipe[0].v && pipe[0].used[i] && pipe[0].src[i] != 0) begin
                for (int k = 1; k <= DEPTH; k++) begin
                    if (s[i*SEL_W +: SEL_W] == 0 && pipe[k].v && pipe[k].rw &&
                        pipe[k].rd == pipe[0].src[i])
                        s[i*SEL_W +: SEL_W] = SEL_W'(k);
                end
            end
        end
        return s;
    endfunction

    // A load is forwardable only from stage 2 onward; with one stage it must
    // clear stage 1 before the consumer may proceed.
    function automatic bit refStall(rec_t id);
        int lastP = (DEPTH == 1) ? 1 : 0;
        if (!id.v) return 0;
        for (int p = 0; p <= lastP; p++) begin
            if (pipe[p].v && pipe[p].mr && pipe[p].rw && pipe[p].rd != 0)
                for (int i = 0; i < NSRC; i++)
                    if (id.used[i] && id.src[i] == pipe[p].rd) return 1;
        end
        return 0;
    endfunction

    task automatic step(input bit r, input bit fl, input rec_t in, output bit st);
        exp_t e;
        rec_t nx;
        @(posedge clk);
        #1;
        rst          = r;
        flush        = fl;
        id_valid     = in.v;
        id_src       = in.src;
        id_src_used  = in.used;
        id_rd        = in.rd;
        id_reg_write = in.rw;
        id_mem_read  = in.mr;

        e.cntValid = known;
        e.sc       = CNT_W'(mStall);
        e.fc       = CNT_W'(mFwd);
        if (r) begin
            e.stall = 1'b0;
            e.sel   = '0;
        end else begin
            e.stall = refStall(in);
            e.sel   = refSel();
        end
        sb.push_back(e);
        st = e.stall;

        if (r) begin
            for (int k = 0; k <= DEPTH; k++) pipe[k] = '0;
            mStall = 0;
            mFwd   = 0;
            known  = 1;
        end else begin
            if (e.stall && mStall < (1 << CNT_W) - 1) mStall++;
            if (e.sel != 0 && mFwd < (1 << CNT_W) - 1) mFwd++;
            nx = (in.v && !e.stall && !fl) ? in : '0;
            pipe.push_front(nx);
            void'(pipe.pop_back());
        end
    endtask

    task automatic issue(input rec_t x);
        bit st;
        int n = 0;
        do begin
            step(0, 0, x, st);
            n++;
        end while (st && n < 4);
        if (st) begin
            checks++;
            errors++;
            $display("FAIL stall_bound: stall still 1 after %0d cycles, required release", n);
        end
    endtask

    task automatic nops(input int n);
        bit st;
        repeat (n) step(0, 0, '0, st);
    endtask

    task automatic doReset();
        bit st;
        repeat (2) step(1, $urandom_range(0, 1), randRec(), st);
    endtask

    exp_t monE;
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            monE = sb.pop_front();
            check("stall", 64'(stall), 64'(monE.stall));
            check("fwd_sel", 64'(fwd_sel), 64'(monE.sel));
            if (monE.cntValid) begin
                check("stall_cnt", 64'(stall_cnt), 64'(monE.sc));
                check("fwd_cnt", 64'(fwd_cnt), 64'(monE.fc));
            end
        end
    end

    initial begin
        bit   st;
        rec_t cur;
        for (int k = 0; k <= DEPTH; k++) pipe.push_back('0);

        // Reset with random ID traffic, then idle
        doReset();
        nops(1);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        check("rst_fwd_cnt", 64'(fwd_cnt), 64'd0);

        // Back-to-back and one-apart RAW on r3
        issue(mk(1, 2'b00, 0, 0, 3, 1, 0));
        issue(mk(1, 2'b01, 3, 0, 9, 0, 0));
        nops(1);
        issue(mk(1, 2'b00, 0, 0, 3, 1, 0));
        nops(1);
        issue(mk(1, 2'b01, 3, 0, 9, 0, 0));
        nops(2);
        check("fwd_cnt_raw", 64'(fwd_cnt), 64'd2);

        // Nearest writer wins; unrelated nearer write does not block
        doReset();
        issue(mk(1, 2'b00, 0, 0, 3, 1, 0));
        issue(mk(1, 2'b00, 0, 0, 3, 1, 0));
        issue(mk(1, 2'b01, 3, 0, 9, 0, 0));
        issue(mk(1, 2'b00, 0, 0, 3, 1, 0));
        issue(mk(1, 2'b00, 0, 0, 4, 1, 0));
        issue(mk(1, 2'b11, 3, 3, 9, 0, 0));
        nops(2);

        // Load-use on src1
        doReset();
        issue(mk(1, 2'b00, 0, 0, 5, 1, 1));
        issue(mk(1, 2'b11, 1, 5, 9, 0, 0));
        nops(2);
        check("stall_cnt_loaduse", 64'(stall_cnt), 64'd1);

        // Register 0 never forwards or stalls
        doReset();
        issue(mk(1, 2'b00, 0, 0, 0, 1, 0));
        issue(mk(1, 2'b11, 0, 0, 9, 0, 0));
        issue(mk(1, 2'b00, 0, 0, 0, 1, 1));
        issue(mk(1, 2'b11, 0, 0, 9, 0, 0));
        nops(2);
        check("r0_stall_cnt", 64'(stall_cnt), 64'd0);
        check("r0_fwd_cnt", 64'(fwd_cnt), 64'd0);

        // Flush during the stall cycle: one bubble only
        doReset();
        issue(mk(1, 2'b00, 0, 0, 7, 1, 1));
        step(0, 1, mk(1, 2'b01, 7, 0, 9, 0, 0), st);
        step(0, 0, mk(1, 2'b01, 7, 0, 9, 0, 0), st);
        nops(3);
        check("flush_stall_cnt", 64'(stall_cnt), 64'd1);

        // Reset during the stall cycle
        doReset();
        issue(mk(1, 2'b00, 0, 0, 7, 1, 1));
        step(1, 0, mk(1, 2'b01, 7, 0, 9, 0, 0), st);
        step(0, 0, mk(1, 2'b01, 7, 0, 9, 0, 0), st);
        check("rststall_stall", 64'(stall), 64'd0);
        nops(2);
        check("rststall_stall_cnt", 64'(stall_cnt), 64'd0);
        check("rststall_fwd_cnt", 64'(fwd_cnt), 64'd0);

        // Random traffic; a stalled instruction stays in ID
        st  = 0;
        cur = randRec();
        for (int n = 0; n < 3000; n++) begin
            if (!st) cur = randRec();
            step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0, cur, st);
        end
        nops(2);

        @(negedge clk);
        #1;
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
